// File: rtl/fetch_seq_pkg.sv
// Shared types and helpers for the BRAM fetch sequencer: FSM states, command
// payload, routing modes and the PE capture-mask decode.
package fetch_seq_pkg;

  localparam int unsigned DIMEN_W = 2;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned NUM_PE  = 4;
  localparam int unsigned WORDS_W = 5;

  localparam logic [SEL_W-1:0] MODE_BCAST  = 2'd0;
  localparam logic [SEL_W-1:0] MODE_SINGLE = 2'd1;
  localparam logic [SEL_W-1:0] MODE_LOADA  = 2'd2;
  localparam logic [SEL_W-1:0] MODE_LOADB  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, STORE, NEXT_PE, DONE_ST
  } state_t;

  typedef struct packed {
    logic               store;
    logic [DIMEN_W-1:0] dimen;
    logic [ADDR_W-1:0]  addr;
    logic [SEL_W-1:0]   pe_sel;
    logic               pe_2x2;
    logic               pe_4;
  } cmd_t;

  // PEs that capture PE_DIN_x for a given routing mode and qualifiers.
  function automatic logic [NUM_PE-1:0] route_mask(input logic [SEL_W-1:0] mode,
                                                   input logic sel_2x2,
                                                   input logic sel_4);
    logic [NUM_PE-1:0] m;
    m = '0;
    case (mode)
      MODE_BCAST:  m = 4'b1111;
      MODE_SINGLE: m = NUM_PE'(1) << {sel_4, sel_2x2};
      MODE_LOADA:  m = sel_2x2 ? 4'b0011 : 4'b1100;
      default:     m = sel_2x2 ? 4'b0101 : 4'b1010;
    endcase
    return m;
  endfunction

  function automatic logic [WORDS_W-1:0] words_for_dimen(input logic [DIMEN_W-1:0] dimen);
    return WORDS_W'(2) << dimen;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Command handshake from the decoder plus the fetch-unit control bundle.
interface fetch_sequencer_if;
  import fetch_seq_pkg::*;

  logic               CMD_VALID;
  logic               CMD_READY;
  logic               CMD_STORE;
  logic [DIMEN_W-1:0] CMD_DIMEN;
  logic [ADDR_W-1:0]  CMD_ADDR;
  logic [SEL_W-1:0]   CMD_PE_SEL;
  logic               CMD_PE_2X2;
  logic               CMD_PE_4;
  logic               FETCH_DONE;
  logic               STORE_DONE;
  logic               ADDR_RST;
  logic               ADDR_START;
  logic               WRADDR_START;
  logic [DIMEN_W-1:0] DIMEN;
  logic [ADDR_W-1:0]  ADDRESS;
  logic [SEL_W-1:0]   PE_SEL;
  logic               PE_SEL_2x2;
  logic               PE_SEL_4;
  logic [NUM_PE-1:0]  PE_LOAD_EN;
  logic               BUSY;
  logic               DONE;

  modport master (
    output CMD_VALID, CMD_STORE, CMD_DIMEN, CMD_ADDR, CMD_PE_SEL, CMD_PE_2X2, CMD_PE_4,
           FETCH_DONE, STORE_DONE,
    input  CMD_READY, ADDR_RST, ADDR_START, WRADDR_START, DIMEN, ADDRESS, PE_SEL,
           PE_SEL_2x2, PE_SEL_4, PE_LOAD_EN, BUSY, DONE
  );

  modport slave (
    input  CMD_VALID, CMD_STORE, CMD_DIMEN, CMD_ADDR, CMD_PE_SEL, CMD_PE_2X2, CMD_PE_4,
           FETCH_DONE, STORE_DONE,
    output CMD_READY, ADDR_RST, ADDR_START, WRADDR_START, DIMEN, ADDRESS, PE_SEL,
           PE_SEL_2x2, PE_SEL_4, PE_LOAD_EN, BUSY, DONE
  );
endinterface

// File: rtl/fetch_sequencer.sv
// LOAD/STORE command sequencer driving the BRAM fetch unit's control inputs.
// Optional STORE_ALL_PE_EN: a broadcast store walks PEs 0..3 at base + 4k.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned BRAM_LAT    = 1,
  parameter int unsigned STORE_WORDS = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  fetch_sequencer_if.slave  bus
);

  if (BRAM_LAT != 1) begin : g_lat_chk
    $error("fetch_sequencer: only BRAM_LAT == 1 is supported");
  end
  if (STORE_WORDS < 1) begin : g_words_chk
    $error("fetch_sequencer: STORE_WORDS must be at least 1");
  end

  state_t            state_q, state_d;
  cmd_t              cmd_q;
  logic [NUM_PE-1:0] pe_load_en_q;
  logic              accept_c;

  assign accept_c = bus.CMD_VALID && (state_q == IDLE);

`ifdef STORE_ALL_PE_EN
  logic [SEL_W-1:0] pe_idx_q;
  logic             all_pe_c;

  assign all_pe_c = cmd_q.store && (cmd_q.pe_sel == MODE_BCAST);

  // PE walk index for broadcast stores; restarts on every accepted command.
  always_ff @(posedge CLK) begin
    if (!RSTN)                  pe_idx_q <= '0;
    else if (accept_c)          pe_idx_q <= '0;
    else if (state_q == NEXT_PE) pe_idx_q <= pe_idx_q + SEL_W'(1);
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cmd_q <= '0;
    end else if (accept_c) begin
      cmd_q <= '{store:  bus.CMD_STORE,
                 dimen:  bus.CMD_DIMEN,
                 addr:   bus.CMD_ADDR,
                 pe_sel: bus.CMD_PE_SEL,
                 pe_2x2: bus.CMD_PE_2X2,
                 pe_4:   bus.CMD_PE_4};
    end
  end

  // Capture strobe trails each FETCH address by the BRAM read latency.
  always_ff @(posedge CLK) begin
    if (!RSTN)                 pe_load_en_q <= '0;
    else if (state_q == FETCH) pe_load_en_q <= route_mask(cmd_q.pe_sel, cmd_q.pe_2x2, cmd_q.pe_4);
    else                       pe_load_en_q <= '0;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.CMD_VALID) state_d = bus.CMD_STORE ? STORE : FETCH;
      FETCH:   if (bus.FETCH_DONE) state_d = DRAIN;
      DRAIN:   state_d = DONE_ST;
      STORE: begin
        if (bus.STORE_DONE) begin
`ifdef STORE_ALL_PE_EN
          state_d = (all_pe_c && (pe_idx_q != SEL_W'(NUM_PE - 1))) ? NEXT_PE : DONE_ST;
`else
          state_d = DONE_ST;
`endif
        end
      end
`ifdef STORE_ALL_PE_EN
      NEXT_PE: state_d = STORE;
`endif
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.CMD_READY    = (state_q == IDLE);
    bus.BUSY         = (state_q != IDLE);
    bus.ADDR_RST     = 1'b0;
    bus.ADDR_START   = 1'b0;
    bus.WRADDR_START = 1'b0;
    bus.DONE         = 1'b0;
    bus.DIMEN        = cmd_q.dimen;
    bus.ADDRESS      = cmd_q.addr;
    bus.PE_SEL       = cmd_q.pe_sel;
    bus.PE_SEL_2x2   = cmd_q.pe_2x2;
    bus.PE_SEL_4     = cmd_q.pe_4;
    bus.PE_LOAD_EN   = pe_load_en_q;
`ifdef STORE_ALL_PE_EN
    if (all_pe_c) begin
      bus.PE_SEL  = pe_idx_q;
      bus.ADDRESS = cmd_q.addr + ADDR_W'(pe_idx_q * STORE_WORDS);
    end
`endif
    case (state_q)
      IDLE:    bus.ADDR_RST = 1'b1;
      FETCH:   bus.ADDR_START = !bus.FETCH_DONE;
      STORE: begin
        bus.WRADDR_START = 1'b1;
        bus.ADDR_START   = !bus.STORE_DONE;
      end
      NEXT_PE: bus.ADDR_RST = 1'b1;
      DONE_ST: begin
        bus.DONE     = 1'b1;
        bus.ADDR_RST = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small fetch-unit counter model.
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if bus();

  fetch_sequencer #(.BRAM_LAT(1), .STORE_WORDS(4)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  // Fetch unit model: address counter cleared by ADDR_RST, advanced by ADDR_START.
  logic [4:0] cnt = '0;
  always @(posedge clk) begin
    if (bus.ADDR_RST)        cnt <= '0;
    else if (bus.ADDR_START) cnt <= cnt + 5'd1;
  end
  assign bus.FETCH_DONE = (cnt == ((5'd2 << bus.DIMEN) - 5'd1));
  assign bus.STORE_DONE = bus.WRADDR_START && (cnt == 5'd3);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic st, input logic [1:0] dimen, input logic [3:0] addr,
                           input logic [1:0] sel, input logic p2x2, input logic p4);
    bus.CMD_STORE  = st;
    bus.CMD_DIMEN  = dimen;
    bus.CMD_ADDR   = addr;
    bus.CMD_PE_SEL = sel;
    bus.CMD_PE_2X2 = p2x2;
    bus.CMD_PE_4   = p4;
    bus.CMD_VALID  = 1'b1;
  endtask

  // Accept a LOAD and follow it cycle by cycle; with hold set the same command
  // stays valid and must be taken only once CMD_READY returns.
  task automatic run_load(input logic [1:0] dimen, input logic [1:0] mode, input logic p2x2,
                          input logic p4, input logic [3:0] base, input logic [3:0] mask,
                          input int n, input bit hold);
    drive_cmd(1'b0, dimen, base, mode, p2x2, p4);
    chk("load_ready_pre", bus.CMD_READY, 1);
    for (int c = 1; c <= n + 3; c++) begin
      step();
      if (!hold) bus.CMD_VALID = 1'b0;
      chk("load_pe_en", bus.PE_LOAD_EN, (c >= 2 && c <= n + 1) ? mask : 4'b0000);
      chk("load_done", bus.DONE, c == n + 2);
      chk("load_ready", bus.CMD_READY, c >= n + 3);
      chk("load_busy", bus.BUSY, c <= n + 2);
      chk("load_addr", bus.ADDRESS, base);
      if (c == 1) chk("load_addr_start", bus.ADDR_START, 1);
      if (c == 1) chk("load_dimen", bus.DIMEN, dimen);
    end
    if (hold) begin
      for (int c = 1; c <= n + 3; c++) begin
        step();
        bus.CMD_VALID = 1'b0;
        chk("held_busy", bus.BUSY, c <= n + 2);
        chk("held_done", bus.DONE, c == n + 2);
        chk("held_pe_en", bus.PE_LOAD_EN, (c >= 2 && c <= n + 1) ? mask : 4'b0000);
      end
    end
  endtask

  task automatic run_store(input logic [1:0] sel, input logic [3:0] base);
    drive_cmd(1'b1, 2'd3, base, sel, 1'b0, 1'b0);
    chk("store_ready_pre", bus.CMD_READY, 1);
    for (int c = 1; c <= 6; c++) begin
      step();
      bus.CMD_VALID = 1'b0;
      chk("store_wr", bus.WRADDR_START, c <= 4);
      chk("store_done", bus.DONE, c == 5);
      chk("store_ready", bus.CMD_READY, c == 6);
      chk("store_pe_sel", bus.PE_SEL, sel);
      chk("store_pe_en", bus.PE_LOAD_EN, 4'b0000);
      chk("store_addr", bus.ADDRESS, base);
    end
  endtask

  initial begin
    drive_cmd(1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    bus.CMD_VALID = 1'b0;
    rstn = 1'b0;
    step();
    step();
    chk("rst_addr_rst", bus.ADDR_RST, 1);
    chk("rst_ready", bus.CMD_READY, 1);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_addr_start", bus.ADDR_START, 0);
    chk("rst_wr", bus.WRADDR_START, 0);
    chk("rst_pe_en", bus.PE_LOAD_EN, 4'b0000);
    chk("rst_address", bus.ADDRESS, 4'd0);
    chk("rst_pe_sel", bus.PE_SEL, 2'd0);
    rstn = 1'b1;
    step();

    run_load(2'd0, 2'd0, 1'b0, 1'b0, 4'd4, 4'b1111, 2, 1'b0);
    run_load(2'd3, 2'd1, 1'b0, 1'b1, 4'd9, 4'b0100, 16, 1'b0);
    run_load(2'd1, 2'd3, 1'b0, 1'b0, 4'd2, 4'b1010, 4, 1'b1);
    run_store(2'd2, 4'd8);

    // Abort a LOAD with reset sampled at the edge ending accept+3.
    drive_cmd(1'b0, 2'd2, 4'd6, 2'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      step();
      bus.CMD_VALID = 1'b0;
    end
    chk("abort_busy_pre", bus.BUSY, 1);
    rstn = 1'b0;
    step();
    chk("abort_addr_rst", bus.ADDR_RST, 1);
    chk("abort_ready", bus.CMD_READY, 1);
    chk("abort_busy", bus.BUSY, 0);
    chk("abort_pe_en", bus.PE_LOAD_EN, 4'b0000);
    chk("abort_address", bus.ADDRESS, 4'd0);
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("abort_no_done", bus.DONE, 0);
    end
    run_load(2'd0, 2'd2, 1'b1, 1'b0, 4'd15, 4'b0011, 2, 1'b0);

`ifdef STORE_ALL_PE_EN
    drive_cmd(1'b1, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 21; c++) begin
      step();
      bus.CMD_VALID = 1'b0;
      chk("allpe_done", bus.DONE, c == 20);
      chk("allpe_ready", bus.CMD_READY, c == 21);
      if (c <= 19 && (c % 5) != 0) begin
        chk("allpe_wr", bus.WRADDR_START, 1);
        chk("allpe_pe_sel", bus.PE_SEL, (c - 1) / 5);
        chk("allpe_addr", bus.ADDRESS, 4 * ((c - 1) / 5));
      end else if (c < 20) begin
        chk("allpe_next_rst", bus.ADDR_RST, 1);
        chk("allpe_next_wr", bus.WRADDR_START, 0);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Command-level controller for the BRAM data-fetch unit. It accepts one LOAD or STORE command from the instruction decoder through a valid/ready handshake.
- For LOAD it drives the fetch unit's address-counter controls (ADDR_RST, ADDR_START) and the PE routing selects for the commanded word count. For STORE it also drives WRADDR_START.
- Per-PE capture strobes are aligned to the one-cycle BRAM read latency. DONE pulses once the last word has landed or been written.
- Sits between the control unit and the fetch unit; it is the only driver of the fetch unit's control inputs.

Parameters:
- BRAM_LAT, 1, read latency in cycles from address to valid doutb. Only 1 is supported; any other value is a compile-time error.
- STORE_WORDS, 4, words written per PE per store. Must match the fetch unit's STORE_DONE count.

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  synchronous active-low reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  sequencer idle; command accepted when CMD_VALID & CMD_READY
- CMD_STORE  in  1  0 = LOAD, 1 = STORE
- CMD_DIMEN  in  2  LOAD length code: 0/1/2/3 -> 2/4/8/16 words
- CMD_ADDR  in  4  BRAM base word address
- CMD_PE_SEL  in  2  routing mode: 0 broadcast, 1 single, 2 LOADA 2x2, 3 LOADB 2x2
- CMD_PE_2X2  in  1  routing qualifier
- CMD_PE_4  in  1  routing qualifier
- FETCH_DONE  in  1  from fetch unit
- STORE_DONE  in  1  from fetch unit
- ADDR_RST  out  1  to fetch unit
- ADDR_START  out  1  to fetch unit
- WRADDR_START  out  1  to fetch unit
- DIMEN  out  2  to fetch unit
- ADDRESS  out  4  to fetch unit
- PE_SEL  out  2  to fetch unit
- PE_SEL_2x2  out  1  to fetch unit
- PE_SEL_4  out  1  to fetch unit
- PE_LOAD_EN  out  4  per-PE capture strobe for PE_DIN_x
- BUSY  out  1  high whenever not in IDLE
- DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset (RSTN=0 at a rising edge): state = IDLE, all command registers cleared.
  - Outputs: ADDR_RST=1, CMD_READY=1, everything else 0.
  - Reset mid-operation aborts immediately. No DONE is issued for the aborted command.
- On accept, register all CMD_* fields. The fetch-unit selects are driven from these registers and stay stable for the whole command. ADDRESS = registered base.
- IDLE: ADDR_RST=1, CMD_READY=1.
  - Accept a LOAD -> FETCH.
  - Accept a STORE -> STORE.
- FETCH: ADDR_START = ~FETCH_DONE.
  - When FETCH_DONE=1 (counter = N-1, last address on the bus) -> DRAIN.
  - FETCH lasts exactly N = 2^(DIMEN+1) cycles.
- DRAIN: one cycle, for BRAM latency -> DONE_ST.
- PE_LOAD_EN:
  - Value is route_mask(PE_SEL, PE_SEL_2x2, PE_SEL_4), registered one cycle behind every FETCH cycle. It is therefore active for N cycles, with the last one in DRAIN. It is 0 at all other times.
  - Mask encoding:
    - mode 0 -> 4'b1111
    - mode 1 -> one-hot at index {PE_4, PE_2x2}
    - mode 2 -> 2x2 ? 4'b0011 : 4'b1100
    - mode 3 -> 2x2 ? 4'b0101 : 4'b1010
- STORE: WRADDR_START=1, ADDR_START = ~STORE_DONE, PE_SEL = registered select.
  - When STORE_DONE=1 -> DONE_ST.
  - STORE lasts STORE_WORDS cycles and writes base+0..base+3.
  - CMD_DIMEN is don't-care for stores.
- DONE_ST: DONE=1, ADDR_RST=1 -> IDLE.
- Load timing, accept at cycle a:
  - FETCH a+1..a+N
  - PE_LOAD_EN a+2..a+N+1
  - DONE at a+N+2
  - CMD_READY at a+N+3
- Store timing, accept at cycle a: WRADDR_START a+1..a+4, DONE a+5.
- ADDRESS is 4 bits; base + offset wraps modulo 16 inside the fetch unit. The sequencer does not check for wrap.
- CMD_VALID while BUSY is ignored (CMD_READY=0). The command must be held until accepted.

Optional Feature:
- Macro: STORE_ALL_PE_EN.
- Defined:
  - A STORE with CMD_PE_SEL=0 iterates PE index k = 0..3.
  - For each k: drive PE_SEL=k and ADDRESS = base + 4k (mod 16), then run STORE for 4 cycles.
  - Between PEs, a NEXT_PE state (1 cycle, ADDR_RST=1) increments k.
  - DONE fires after PE3, at accept + 20.
  - Stores with CMD_PE_SEL != 0 behave as in the base design.
- Undefined: a store handles the single PE given by CMD_PE_SEL. No NEXT_PE state exists.

Decomposition:
- Package fetch_seq_pkg:
  - state enum (IDLE, FETCH, DRAIN, STORE, NEXT_PE, DONE_ST)
  - routing-mode localparams
  - function route_mask(), returning the 4-bit PE mask
  - function words_for_dimen()
- No sub-module needed. The registered command block and FSM sit in one module.

Test Plan:
- LOAD, DIMEN=0, mode 0, base 4 -> ADDR_START 2 cycles, PE_LOAD_EN=1111 for 2 cycles starting accept+2, DONE at accept+4.
- LOAD, DIMEN=3, mode 1, PE_4=1, PE_2x2=0 -> 16 FETCH cycles, PE_LOAD_EN=0100 for 16 cycles, DONE at accept+18.
- LOAD, DIMEN=1, mode 3, PE_2x2=0 -> PE_LOAD_EN=1010 for 4 cycles. Also: CMD_VALID held while BUSY -> not accepted until CMD_READY.
- STORE, PE_SEL=2, base 8 -> WRADDR_START 4 cycles, DONE at accept+5, PE_SEL=2 throughout, PE_LOAD_EN=0.
- LOAD, DIMEN=2, with RSTN=0 at accept+3 -> next cycle IDLE, ADDR_RST=1, no DONE. A new command is accepted normally afterwards.
- STORE_ALL_PE_EN defined, STORE, PE_SEL=0, base 0 -> PE_SEL steps 0,1,2,3 and ADDRESS steps 0,4,8,12, DONE at accept+20.
